// File: rtl/bus_arbit_rr.sv
// bus_arbit_rr: N-master round-robin bus arbiter with a registered one-hot grant.
// The current owner keeps the bus for as long as its request stays high. When it
// lets go, the bus moves straight to the next requester in circular order, with
// no dead cycle in between.
// Optional feature: define BUS_ARBIT_TIMEOUT_EN to force a handover after
// MAX_HOLD consecutive grant cycles whenever another master is waiting.
module bus_arbit_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         m_req,
  output logic [NUM_MASTERS-1:0]         m_grant,
  output logic                           grant_valid,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           timeout_evt
);

  localparam int ID_W = $clog2(NUM_MASTERS);
`ifdef BUS_ARBIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
`endif

  // Reject parameter values outside the supported range when the design is elaborated.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_param_check
    $error("bus_arbit_rr: NUM_MASTERS must be 2..16 and MAX_HOLD must be 2..256");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic                   valid_q;
  logic [ID_W-1:0]        id_q;
  logic [ID_W-1:0]        lastId_q;
`ifdef BUS_ARBIT_TIMEOUT_EN
  logic [CNT_W-1:0]       holdCnt_q;
  logic                   timeout_q;
`endif

  logic [NUM_MASTERS-1:0] candReq;
  logic [ID_W-1:0]        scanIdx;
  logic                   winFound;
  logic [ID_W-1:0]        winId;
  logic [NUM_MASTERS-1:0] winOneHot;
  logic                   ownerReq;
  logic                   forceRelease;

  // Circular priority scan that starts one past the last owner. The current
  // owner is masked out of the scan. When the owner has dropped its request, the
  // mask changes nothing. On a forced release, the mask keeps the bus from
  // handing straight back to the same master.
  always_comb begin
    candReq  = m_req & ~grant_q;
    scanIdx  = '0;
    winFound = 1'b0;
    winId    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      scanIdx = ID_W'((int'(lastId_q) + 1 + k) % NUM_MASTERS);
      if (!winFound && candReq[scanIdx]) begin
        winFound = 1'b1;
        winId    = scanIdx;
      end
    end
  end

  // One-hot form of the scan winner, plus the owner's live request bit.
  always_comb begin
    winOneHot        = '0;
    winOneHot[winId] = 1'b1;
    ownerReq         = |(m_req & grant_q);
  end

  // A forced release needs three things: a saturated hold counter, an owner
  // that still wants the bus, and another master waiting.
`ifdef BUS_ARBIT_TIMEOUT_EN
  always_comb begin
    forceRelease = ownerReq && winFound && (holdCnt_q == CNT_W'(MAX_HOLD));
  end
`else
  always_comb begin
    forceRelease = 1'b0;
  end
`endif

  // Arbitration FSM. Every output comes straight from a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      lastId_q  <= ID_W'(NUM_MASTERS - 1);
`ifdef BUS_ARBIT_TIMEOUT_EN
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARBIT_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (winFound) begin
            state_q   <= OWNED;
            grant_q   <= winOneHot;
            valid_q   <= 1'b1;
            id_q      <= winId;
            lastId_q  <= winId;
`ifdef BUS_ARBIT_TIMEOUT_EN
            holdCnt_q <= CNT_W'(1);
`endif
          end
        end
        OWNED: begin
          if (!ownerReq && !winFound) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
`ifdef BUS_ARBIT_TIMEOUT_EN
            holdCnt_q <= '0;
`endif
          end else if (!ownerReq || forceRelease) begin
            grant_q   <= winOneHot;
            valid_q   <= 1'b1;
            id_q      <= winId;
            lastId_q  <= winId;
`ifdef BUS_ARBIT_TIMEOUT_EN
            holdCnt_q <= CNT_W'(1);
            timeout_q <= forceRelease;
`endif
          end else begin
`ifdef BUS_ARBIT_TIMEOUT_EN
            if (holdCnt_q != CNT_W'(MAX_HOLD)) begin
              holdCnt_q <= holdCnt_q + CNT_W'(1);
            end
`endif
          end
        end
      endcase
    end
  end

  assign m_grant     = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
`ifdef BUS_ARBIT_TIMEOUT_EN
  assign timeout_evt = timeout_q;
`else
  assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbit_rr.sv
// tb_bus_arbit_rr: directed self-checking bench for bus_arbit_rr (4 masters, MAX_HOLD=4).
// The forced-handover expectations follow BUS_ARBIT_TIMEOUT_EN.
module tb_bus_arbit_rr;

  localparam int NumMasters = 4;
  localparam int MaxHold    = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NumMasters-1:0] m_req;
  logic [NumMasters-1:0] m_grant;
  logic                  grant_valid;
  logic [1:0]            grant_id;
  logic                  timeout_evt;

  int checkCount = 0;
  int errorCount = 0;
  bit invOn      = 1'b0;

  bus_arbit_rr #(
    .NUM_MASTERS(NumMasters),
    .MAX_HOLD   (MaxHold)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m_req      (m_req),
    .m_grant    (m_grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .timeout_evt(timeout_evt)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is not the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at time %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive a request vector, then let one rising edge pass and settle just after it.
  task automatic applyStimulus(input logic [3:0] req);
    m_req = req;
    @(posedge clk);
    #1;
  endtask

  // Compare all four outputs against hand-computed expectations.
  task automatic checkGrant(input string tag, input logic [3:0] expGrant, input logic [1:0] expId, input logic expTmo);
    checkOutput({tag, ".grant"}, 32'(m_grant), 32'(expGrant));
    checkOutput({tag, ".valid"}, 32'(grant_valid), 32'(expGrant != 4'b0000));
    checkOutput({tag, ".id"}, 32'(grant_id), 32'(expId));
    checkOutput({tag, ".tmo"}, 32'(timeout_evt), 32'(expTmo));
  endtask

  // Check the structural output invariants on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (invOn) begin
      checkOutput("inv.onehot", 32'($onehot0(m_grant)), 32'(1));
      checkOutput("inv.valid", 32'(grant_valid), 32'(|m_grant));
      if (grant_valid) begin
        checkOutput("inv.id", 32'(4'b0001 << grant_id), 32'(m_grant));
      end else begin
        checkOutput("inv.idleid", 32'(grant_id), 32'(0));
      end
    end
  end

  // Stop the run with a failure if it goes on far too long.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [1:0] rrOrder [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    reset = 1'b1;
    m_req = 4'b0000;
    @(posedge clk);
    #1;
    invOn = 1'b1;

    applyStimulus(4'b0000);
    checkGrant("reset", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0000);
      checkGrant("idle", 4'b0000, 2'd0, 1'b0);
    end

    $display("[TB] round-robin with all masters requesting");
    applyStimulus(4'b1111);
    checkGrant("rr.first", 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int h = 0; h < 2; h++) begin
        applyStimulus(4'b1111);
        checkGrant("rr.hold", 4'b0001 << rrOrder[i], rrOrder[i], 1'b0);
      end
      applyStimulus(4'b1111 & ~(4'b0001 << rrOrder[i]));
      checkGrant("rr.next", 4'b0001 << rrOrder[i+1], rrOrder[i+1], 1'b0);
    end
    applyStimulus(4'b0000);
    checkGrant("rr.release", 4'b0000, 2'd0, 1'b0);

    $display("[TB] single requester");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0100);
      checkGrant("single.hold", 4'b0100, 2'd2, 1'b0);
    end
    applyStimulus(4'b0000);
    checkGrant("single.drop", 4'b0000, 2'd0, 1'b0);

    $display("[TB] wrap-around handover");
    applyStimulus(4'b1000);
    checkGrant("wrap.own3", 4'b1000, 2'd3, 1'b0);
    applyStimulus(4'b1011);
    checkGrant("wrap.hold3", 4'b1000, 2'd3, 1'b0);
    applyStimulus(4'b0011);
    checkGrant("wrap.to0", 4'b0001, 2'd0, 1'b0);
    applyStimulus(4'b0010);
    checkGrant("wrap.to1", 4'b0010, 2'd1, 1'b0);
    applyStimulus(4'b0000);
    checkGrant("wrap.idle", 4'b0000, 2'd0, 1'b0);

    $display("[TB] reset during ownership");
    applyStimulus(4'b0100);
    checkGrant("rst.own2", 4'b0100, 2'd2, 1'b0);
    reset = 1'b1;
    applyStimulus(4'b0100);
    checkGrant("rst.drop", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    applyStimulus(4'b0101);
    checkGrant("rst.m0wins", 4'b0001, 2'd0, 1'b0);
    applyStimulus(4'b0000);
    checkGrant("rst.idle", 4'b0000, 2'd0, 1'b0);
    reset = 1'b1;
    applyStimulus(4'b0000);
    reset = 1'b0;
    applyStimulus(4'b1100);
    checkGrant("rst.lastid", 4'b0100, 2'd2, 1'b0);
    applyStimulus(4'b0000);

    $display("[TB] hold limit");
    reset = 1'b1;
    applyStimulus(4'b0000);
    reset = 1'b0;
    applyStimulus(4'b0010);
    checkGrant("hold.own1", 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0011);
      checkGrant("hold.keep1", 4'b0010, 2'd1, 1'b0);
    end
    applyStimulus(4'b0011);
`ifdef BUS_ARBIT_TIMEOUT_EN
    checkGrant("hold.forced", 4'b0001, 2'd0, 1'b1);
    applyStimulus(4'b0011);
    checkGrant("hold.pulse", 4'b0001, 2'd0, 1'b0);
`else
    checkGrant("hold.noforce", 4'b0010, 2'd1, 1'b0);
    applyStimulus(4'b0011);
    checkGrant("hold.noforce2", 4'b0010, 2'd1, 1'b0);
`endif
    applyStimulus(4'b0010);
    checkGrant("hold.back1", 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0010);
      checkGrant("hold.alone", 4'b0010, 2'd1, 1'b0);
    end
    applyStimulus(4'b0000);
    checkGrant("hold.idle", 4'b0000, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/bus_arbit_rr.md
Name: bus_arbit_rr

Overview:
Parametrised N-master bus arbiter with round-robin fairness and a registered one-hot grant. Successor to the single-master request/grant arbiter; sits between bus masters and the shared bus mux and drives its select.
- Owner keeps the bus while its request stays high.
- Handover to the next requester happens with no dead cycle.
- Optional hold-timeout forces release so a master cannot starve the others.

Parameters:
- NUM_MASTERS, 4, number of requesting masters; legal range 2..16.
- MAX_HOLD, 16, max consecutive grant cycles before forced handover (timeout feature only); legal range 2..256.
- Derived localparam ID_W = $clog2(NUM_MASTERS): grant_id width.
- Derived localparam CNT_W = $clog2(MAX_HOLD)+1: hold counter width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- m_req  input  NUM_MASTERS  request per master; bit i = master i; level-sensitive.
- m_grant  output  NUM_MASTERS  registered one-hot grant; all-zero when bus idle.
- grant_valid  output  1  registered; 1 when any m_grant bit is set.
- grant_id  output  ID_W  registered binary index of owner; 0 when idle.
- timeout_evt  output  1  registered one-cycle pulse on forced handover; constant 0 when feature compiled out.

Behaviour:
- Reset: synchronous, active-high. Sampled at rising clk.
  - On reset: m_grant=0, grant_valid=0, grant_id=0, timeout_evt=0, state=IDLE, hold_cnt=0.
  - On reset: last_id=NUM_MASTERS-1, so master 0 has top priority after reset.
  - Reset overrides everything, including mid-ownership; the grant drops at that edge.
- States: IDLE (no owner), OWNED (one owner, index held in grant_id).
- Priority search: circular scan starting at (last_id+1) mod NUM_MASTERS; first set m_req bit wins. Wraps NUM_MASTERS-1 -> 0.
- IDLE:
  - Any m_req bit set at edge k -> OWNED.
  - At the same edge, m_grant = one-hot winner, grant_id = winner, last_id = winner, hold_cnt=1.
  - Latency: request present before edge k gives grant visible after edge k (1 cycle).
- OWNED, owner's m_req=1:
  - Grant held; hold_cnt increments, saturating at MAX_HOLD.
  - Other requests are ignored (no preemption) unless the timeout feature fires.
- OWNED, owner's m_req=0 at edge k:
  - If another request is set, grant moves to the search winner at edge k: no idle cycle, no overlap, hold_cnt=1, last_id updated.
  - If no other request is set -> IDLE; m_grant=0, grant_valid=0, grant_id=0. last_id keeps the previous owner.
- Simultaneous requests: resolved only by the circular scan, never by fixed index.
- Owner drops and re-raises in the same cycle: it is not visible (level sampled), so ownership continues.
- m_grant is always one-hot or zero. Asserting two or more bits is a design error; the bench checks for it.
- grant_valid == |m_grant, and grant_id is consistent with m_grant, on every cycle.
- Unknown (X) requests are not special-cased. Bench drives known values only.

Optional Feature:
- Macro: BUS_ARBIT_TIMEOUT_EN.
- Defined, at edge k in OWNED:
  - Condition: hold_cnt == MAX_HOLD, owner still requesting, and another master requesting.
  - Grant moves to the search winner excluding the owner; hold_cnt=1; timeout_evt=1 for one cycle.
  - If no other master is requesting, the owner keeps the bus and hold_cnt stays saturated.
- Not defined: no forced release; hold_cnt logic may be removed; timeout_evt tied to 0.

Test Plan:
- Reset, then m_req=4'b0000 -> m_grant=0, grant_valid=0, grant_id=0 on every cycle.
- From IDLE, m_req=4'b1111 held, each owner drops its request for one cycle after 3 grant cycles -> grant order 0,1,2,3,0, no idle cycles between owners.
- m_req=4'b0100 at cycle 5 -> m_grant=4'b0100, grant_id=2 after the next edge. Drop at cycle 10 -> m_grant=0 after that edge.
- Owner 3 drops while m_req=4'b0011 -> grant moves to master 0 (wrap-around). A later handover with master 1 still requesting -> master 1.
- Assert reset while master 2 is owner -> m_grant=0 after the edge. Then m_req=4'b0101 -> master 0 wins.
- BUS_ARBIT_TIMEOUT_EN, MAX_HOLD=4: master 1 holds with m_req=4'b0011 -> after 4 grant cycles, m_grant=4'b0001 with a 1-cycle timeout_evt. Repeat with m_req=4'b0010 -> master 1 keeps the bus and timeout_evt stays 0.
